dadda_mul_pipe: RTL

Parametrised, pipelined Dadda-tree multiplier with a per-transaction exact/approximate mode and valid/ready flow control on both sides. It follows the combinational `dadda_8` and `approx1_dadda_8` blocks. It generalises them to any even WIDTH and a configurable number of approximated LSB columns, and adds pipelining, back-pressure and tag pass-through. It sits between operand producers and accumulator/consumer logic in the multiplier datapath.

---
 rtl/dadda_pkg.sv | 77 +++++++
 rtl/dadda_reduce.sv | 124 ++++++++++++
 rtl/dadda_mul_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dadda_pkg.sv
// dadda_pkg: shared types and helpers for the pipelined Dadda multiplier.
//   dadda_heights(width) - Dadda target heights d_j (2, 3, 4, 6, 9, ...),
//                          ascending, keeping only d_j < width; unused
//                          entries are zero.
//   num_stages(width)    - number of reduction stages for a width x width
//                          multiply (count of non-zero dadda_heights).
//   ha / fa              - half / full adder cells, returning {carry, sum}.
//   approx_product       - golden model of the approximate product, for
//                          reuse by benches and reference checks.
package dadda_pkg;

  localparam int MAX_STAGES = 16;

  typedef logic [MAX_STAGES-1:0][7:0] dheights_t;

  function automatic dheights_t dadda_heights(input int width);
    dheights_t d;
    int cur;
    d   = '0;
    cur = 2;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (cur < width) begin
        d[i] = 8'(cur);
      end
      cur = (cur * 3) / 2;
    end
    return d;
  endfunction

  function automatic int num_stages(input int width);
    int cur;
    int n;
    cur = 2;
    n   = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (cur < width) begin
        n++;
      end
      cur = (cur * 3) / 2;
    end
    return n;
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Columns below k contribute only the OR of their bits; the rest add up
  // their full popcount.
  function automatic logic [63:0] approx_product(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int width,
                                                 input int k);
    logic [63:0] res;
    int cnt;
    res = '0;
    for (int c = 0; c < 2 * width; c++) begin
      cnt = 0;
      for (int i = 0; i < width; i++) begin
        if (c - i >= 0 && c - i < width) begin
          cnt += int'(a[c-i] & b[i]);
        end
      end
      if (c < k) begin
        res += 64'(cnt != 0) << c;
      end else begin
        res += 64'(cnt) << c;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dadda_reduce.sv
// dadda_reduce: combinational Dadda reduction of a WIDTH x WIDTH partial
// product matrix down to two rows.
//   pp     in  WIDTH x WIDTH  pp[i][j] = a[j] & b[i], weight 2^(i+j)
//   approx in  1              approximate the low APPROX_COLS columns
//   row0   out 2*WIDTH        first reduced row
//   row1   out 2*WIDTH        second reduced row (row0 + row1 = product)
// In approx mode the low columns are removed from the tree (their bits are
// forced to 0, so they produce and absorb no carries) and their OR is placed
// directly on row0 with row1 held at 0 there, so the final adder cannot
// carry through them either.
module dadda_reduce
  import dadda_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp,
  input  logic                        approx,
  output logic [2*WIDTH-1:0]          row0,
  output logic [2*WIDTH-1:0]          row1
);

  localparam int NC         = 2 * WIDTH;
  localparam int CAP        = 2 * WIDTH;
  localparam int NUM_STAGES = num_stages(WIDTH);
  localparam dheights_t D   = dadda_heights(WIDTH);

  logic [NC-1:0] or_col;
  logic [NC-1:0] approx_mask;

  for (genvar gi = 0; gi < NC; gi++) begin : g_mask
    assign approx_mask[gi] = approx && (gi < APPROX_COLS);
  end

  always_comb begin
    or_col = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        or_col[i+j] = or_col[i+j] | pp[i][j];
      end
    end
  end

  // Heights and bit positions depend only on WIDTH, so every index below
  // folds to a constant once the loops are unrolled.
  always_comb begin : tree
    logic [CAP-1:0] col [NC];
    logic [CAP-1:0] nxt [NC];
    int             h   [NC];
    int             nh  [NC];
    int             idx;
    int             d;
    logic [1:0]     cs;

    for (int c = 0; c < NC; c++) begin
      col[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end
    idx  = 0;
    d    = 0;
    cs   = '0;
    row0 = '0;
    row1 = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][h[i+j]] = pp[i][j] & ~approx_mask[i+j];
        h[i+j]           = h[i+j] + 1;
      end
    end

    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      d = int'(D[s]);
      for (int c = 0; c < NC; c++) begin
        nxt[c] = '0;
        nh[c]  = 0;
      end
      for (int c = 0; c < NC; c++) begin
        idx = 0;
        // Carries already landed in nxt[c] from column c-1 count toward the
        // target height; use a HA when one bit of reduction is enough.
        for (int r = 0; r < WIDTH; r++) begin
          if (h[c] - idx + nh[c] > d) begin
            if (h[c] - idx + nh[c] == d + 1) begin
              cs  = ha(col[c][idx], col[c][idx+1]);
              idx = idx + 2;
            end else begin
              cs  = fa(col[c][idx], col[c][idx+1], col[c][idx+2]);
              idx = idx + 3;
            end
            nxt[c][nh[c]] = cs[0];
            nh[c]         = nh[c] + 1;
            if (c + 1 < NC) begin
              nxt[c+1][nh[c+1]] = cs[1];
              nh[c+1]           = nh[c+1] + 1;
            end
          end
        end
        for (int k = 0; k < CAP; k++) begin
          if (k >= idx && k < h[c]) begin
            nxt[c][nh[c]] = col[c][k];
            nh[c]         = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < NC; c++) begin
        col[c] = nxt[c];
        h[c]   = nh[c];
      end
    end

    for (int c = 0; c < NC; c++) begin
      row0[c] = (h[c] >= 1) ? col[c][0] : 1'b0;
      row1[c] = (h[c] >= 2) ? col[c][1] : 1'b0;
      if (approx_mask[c]) begin
        row0[c] = or_col[c];
        row1[c] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: three-stage pipelined WIDTH x WIDTH Dadda multiplier with
// per-transaction exact/approximate mode and valid/ready on both sides.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in1, in2 unsigned operands,
//                       approx selects approximate mode, in_tag sideband
//   out_valid/out_ready result handshake; out product, overflow when the
//                       upper WIDTH bits are non-zero, out_tag, out_approx
// Stage 1 holds operands, stage 2 the two reduced rows, stage 3 the final
// carry-lookahead sum. The whole pipe advances together whenever the output
// register is empty or being drained; otherwise every stage holds.
module dadda_mul_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               overflow,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_approx
);

  localparam int PW = 2 * WIDTH;
  localparam int NG = PW / 4;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: operands
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_approx_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a_reg      <= in1;
      s1_b_reg      <= in2;
      s1_approx_reg <= approx;
      s1_tag_reg    <= in_tag;
    end
  end

  logic [WIDTH-1:0][WIDTH-1:0] pp;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pp_col
      assign pp[gi][gj] = s1_a_reg[gj] & s1_b_reg[gi];
    end
  end

  logic [PW-1:0] row0_next;
  logic [PW-1:0] row1_next;

  dadda_reduce #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_reduce (
    .pp     (pp),
    .approx (s1_approx_reg),
    .row0   (row0_next),
    .row1   (row1_next)
  );

  // Stage 2: reduced rows
  logic             s2_valid_reg;
  logic [PW-1:0]    s2_row0_reg;
  logic [PW-1:0]    s2_row1_reg;
  logic             s2_approx_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_row0_reg   <= row0_next;
      s2_row1_reg   <= row1_next;
      s2_approx_reg <= s1_approx_reg;
      s2_tag_reg    <= s1_tag_reg;
    end
  end

  // Final adder: 4-bit CLA groups, group carries from a second lookahead
  // level rather than rippling group to group.
  logic [PW-1:0] p_bit;
  logic [PW-1:0] g_bit;
  logic [PW-1:0] bit_c;
  logic [PW-1:0] sum_next;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  logic          unused_carry;

  assign p_bit        = s2_row0_reg ^ s2_row1_reg;
  assign g_bit        = s2_row0_reg & s2_row1_reg;
  assign unused_carry = grp_c[NG];

  for (genvar gi = 0; gi < NG; gi++) begin : g_cla
    localparam int B = 4 * gi;
    assign grp_g[gi] = g_bit[B+3]
                     | (p_bit[B+3] & g_bit[B+2])
                     | (p_bit[B+3] & p_bit[B+2] & g_bit[B+1])
                     | (p_bit[B+3] & p_bit[B+2] & p_bit[B+1] & g_bit[B]);
    assign grp_p[gi] = &p_bit[B+3:B];
    assign bit_c[B]   = grp_c[gi];
    assign bit_c[B+1] = g_bit[B] | (p_bit[B] & grp_c[gi]);
    assign bit_c[B+2] = g_bit[B+1] | (p_bit[B+1] & g_bit[B])
                      | (p_bit[B+1] & p_bit[B] & grp_c[gi]);
    assign bit_c[B+3] = g_bit[B+2] | (p_bit[B+2] & g_bit[B+1])
                      | (p_bit[B+2] & p_bit[B+1] & g_bit[B])
                      | (p_bit[B+2] & p_bit[B+1] & p_bit[B] & grp_c[gi]);
    assign sum_next[B+3:B] = p_bit[B+3:B] ^ bit_c[B+3:B];
  end

  always_comb begin
    logic term;
    term  = 1'b0;
    grp_c = '0;
    for (int g = 1; g <= NG; g++) begin
      for (int k = 0; k < g; k++) begin
        term = grp_g[k];
        for (int m = k + 1; m < g; m++) begin
          term = term & grp_p[m];
        end
        grp_c[g] = grp_c[g] | term;
      end
    end
  end

  // Stage 3: result register, drives the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      overflow   <= 1'b0;
      out_tag    <= '0;
      out_approx <= 1'b0;
    end else if (advance) begin
      out_valid  <= s2_valid_reg;
      out        <= sum_next;
      overflow   <= |sum_next[PW-1:WIDTH];
      out_tag    <= s2_tag_reg;
      out_approx <= s2_approx_reg;
    end
  end

endmodule
